// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control unit for the 16-bit processor.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB, decodes the 5-bit opcode,
// holds the N/Z flags, handshakes with the shared memory port and drives
// registered, state-qualified control strobes to the datapath.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   opcode[4:0]          instruction register; sampled at the end of DECODE
//   alu_n, alu_z         ALU result flags, sampled at the end of EXEC
//   mem_ready            memory completes the current access this cycle
//   mem_req, mem_sel     memory request, 0 = fetch / 1 = data
//   MemWrite             data write strobe (st in MEM)
//   ir_load              one-cycle pulse to latch the fetched instruction
//   ALUOp/ALUSrc/ExtSel  EXEC controls
//   RegWrite/RegDst/WBSrc/PCSrc/pc_enable  WB controls
//   n_flag, z_flag       architectural flags
//   illegal              one-cycle WB pulse for an undefined opcode
//   fault                sticky memory-timeout indication
module cpu_ctrl_fsm #(
  parameter int unsigned MAX_WAIT      = 16,
  parameter bit          ARITH_SETS_NZ = 1'b1,
  parameter int unsigned WCNT_W        = $clog2(MAX_WAIT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       MemWrite,
  output logic       ir_load,
  output logic       ALUOp,
  output logic       ALUSrc,
  output logic       ExtSel,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [2:0] WBSrc,
  output logic [1:0] PCSrc,
  output logic       pc_enable,
  output logic       n_flag,
  output logic       z_flag,
  output logic       illegal,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  localparam logic [1:0] PC_OFS  = 2'b00;
  localparam logic [1:0] PC_REG  = 2'b01;
  localparam logic [1:0] PC_NEXT = 2'b10;

  localparam logic [2:0] WB_MEM  = 3'b000;
  localparam logic [2:0] WB_ALU  = 3'b001;
  localparam logic [2:0] WB_PC2  = 3'b010;
  localparam logic [2:0] WB_RY   = 3'b011;
  localparam logic [2:0] WB_IMM8 = 3'b100;
  localparam logic [2:0] WB_HI   = 3'b101;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t              r_state;
  logic [4:0]          r_op_q;
  logic [WCNT_W-1:0]   r_wcnt;

  logic [4:0] w_op;
  logic       w_legal;
  logic       w_alu_sub;
  logic       w_alu_imm;
  logic       w_ext11;
  logic       w_sets_nz;
  logic       w_is_mem;
  logic       w_is_st;
  logic       w_reg_wr;
  logic       w_reg_dst;
  logic [2:0] w_wb_src;
  logic [1:0] w_pc_src;
  logic       w_wait_last;

  // Outputs are registered for the state being entered, so while leaving
  // DECODE the live opcode is decoded; afterwards the latched copy.
  assign w_op        = (r_state == S_DECODE) ? opcode : r_op_q;
  assign w_wait_last = (r_wcnt == WCNT_LAST);

  // Opcode decode; branch conditions use the registered flags, which a jump
  // never modifies, so they already hold the WB-time value.
  always_comb begin
    w_legal   = 1'b1;
    w_alu_sub = 1'b0;
    w_alu_imm = 1'b0;
    w_ext11   = 1'b0;
    w_sets_nz = 1'b0;
    w_is_mem  = 1'b0;
    w_is_st   = 1'b0;
    w_reg_wr  = 1'b0;
    w_reg_dst = 1'b0;
    w_wb_src  = WB_MEM;
    w_pc_src  = PC_NEXT;
    case (w_op)
      OP_MV:    begin w_reg_wr = 1'b1; w_wb_src = WB_RY; end
      OP_ADD:   begin w_reg_wr = 1'b1; w_wb_src = WB_ALU; w_sets_nz = ARITH_SETS_NZ; end
      OP_SUB:   begin w_reg_wr = 1'b1; w_wb_src = WB_ALU; w_alu_sub = 1'b1;
                      w_sets_nz = ARITH_SETS_NZ; end
      OP_CMP:   begin w_alu_sub = 1'b1; w_sets_nz = 1'b1; end
      OP_LD:    begin w_is_mem = 1'b1; w_reg_wr = 1'b1; w_wb_src = WB_MEM; end
      OP_ST:    begin w_is_mem = 1'b1; w_is_st = 1'b1; end
      OP_JR:    w_pc_src = PC_REG;
      OP_JZR:   if (z_flag) w_pc_src = PC_REG;
      OP_JNR:   if (n_flag) w_pc_src = PC_REG;
      OP_CALLR: begin w_reg_wr = 1'b1; w_reg_dst = 1'b1; w_wb_src = WB_PC2;
                      w_pc_src = PC_REG; end
      OP_MVI:   begin w_reg_wr = 1'b1; w_wb_src = WB_IMM8; end
      OP_ADDI:  begin w_reg_wr = 1'b1; w_wb_src = WB_ALU; w_alu_imm = 1'b1;
                      w_sets_nz = ARITH_SETS_NZ; end
      OP_SUBI:  begin w_reg_wr = 1'b1; w_wb_src = WB_ALU; w_alu_imm = 1'b1;
                      w_alu_sub = 1'b1; w_sets_nz = ARITH_SETS_NZ; end
      OP_CMPI:  begin w_alu_imm = 1'b1; w_alu_sub = 1'b1; w_sets_nz = 1'b1; end
      OP_MVHI:  begin w_reg_wr = 1'b1; w_wb_src = WB_HI; end
      OP_J:     begin w_ext11 = 1'b1; w_pc_src = PC_OFS; end
      OP_JZ:    begin w_ext11 = 1'b1; if (z_flag) w_pc_src = PC_OFS; end
      OP_JN:    begin w_ext11 = 1'b1; if (n_flag) w_pc_src = PC_OFS; end
      OP_CALL:  begin w_ext11 = 1'b1; w_reg_wr = 1'b1; w_reg_dst = 1'b1;
                      w_wb_src = WB_PC2; w_pc_src = PC_OFS; end
      default:  w_legal = 1'b0;
    endcase
  end

  // State machine with outputs registered for the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_wcnt    <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_sel   <= 1'b0;
      MemWrite  <= 1'b0;
      ir_load   <= 1'b0;
      ALUOp     <= 1'b0;
      ALUSrc    <= 1'b0;
      ExtSel    <= 1'b0;
      RegWrite  <= 1'b0;
      RegDst    <= 1'b0;
      WBSrc     <= WB_MEM;
      PCSrc     <= PC_NEXT;
      pc_enable <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      mem_req   <= 1'b0;
      mem_sel   <= 1'b0;
      MemWrite  <= 1'b0;
      ir_load   <= 1'b0;
      ALUOp     <= 1'b0;
      ALUSrc    <= 1'b0;
      ExtSel    <= 1'b0;
      RegWrite  <= 1'b0;
      RegDst    <= 1'b0;
      WBSrc     <= WB_MEM;
      PCSrc     <= PC_NEXT;
      pc_enable <= 1'b0;
      illegal   <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // First cycle after reset has no request out yet: raise it.
          if (!mem_req) begin
            mem_req <= 1'b1;
            r_wcnt  <= '0;
          end else if (mem_ready) begin
            ir_load <= 1'b1;
            r_state <= S_DECODE;
          end else if (w_wait_last) begin
            r_wcnt  <= r_wcnt + WCNT_W'(1);
            fault   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wcnt  <= r_wcnt + WCNT_W'(1);
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          r_op_q  <= opcode;
          ALUOp   <= w_alu_sub;
          ALUSrc  <= w_alu_imm;
          ExtSel  <= w_ext11;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_sets_nz) begin
            n_flag <= alu_n;
            z_flag <= alu_z;
          end
          if (w_is_mem) begin
            mem_req  <= 1'b1;
            mem_sel  <= 1'b1;
            MemWrite <= w_is_st;
            r_wcnt   <= '0;
            r_state  <= S_MEM;
          end else begin
            RegWrite  <= w_reg_wr;
            RegDst    <= w_reg_dst;
            WBSrc     <= w_wb_src;
            PCSrc     <= w_pc_src;
            pc_enable <= 1'b1;
            illegal   <= ~w_legal;
            r_state   <= S_WB;
          end
        end
        S_MEM: begin
          // Completion on the last allowed wait cycle still wins over fault.
          if (mem_ready) begin
            RegWrite  <= w_reg_wr;
            RegDst    <= w_reg_dst;
            WBSrc     <= w_wb_src;
            PCSrc     <= w_pc_src;
            pc_enable <= 1'b1;
            illegal   <= ~w_legal;
            r_state   <= S_WB;
          end else if (w_wait_last) begin
            r_wcnt  <= r_wcnt + WCNT_W'(1);
            fault   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wcnt   <= r_wcnt + WCNT_W'(1);
            mem_req  <= 1'b1;
            mem_sel  <= 1'b1;
            MemWrite <= w_is_st;
          end
        end
        S_WB: begin
          mem_req <= 1'b1;
          r_wcnt  <= '0;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed, table-driven bench for cpu_ctrl_fsm.
// Two instances share stimulus: u_dut1 (ARITH_SETS_NZ=1) and u_dut0
// (ARITH_SETS_NZ=0); expected values are hand-computed per instruction.
module tb_cpu_ctrl_fsm;

  localparam logic [4:0] OP_MV = 5'b00000, OP_ADD = 5'b00001, OP_SUB = 5'b00010;
  localparam logic [4:0] OP_CMP = 5'b00011, OP_LD = 5'b00100, OP_ST = 5'b00101;
  localparam logic [4:0] OP_JR = 5'b01000, OP_JZR = 5'b01001, OP_JNR = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100, OP_MVI = 5'b10000, OP_ADDI = 5'b10001;
  localparam logic [4:0] OP_SUBI = 5'b10010, OP_CMPI = 5'b10011, OP_MVHI = 5'b10110;
  localparam logic [4:0] OP_J = 5'b11000, OP_JZ = 5'b11001, OP_JN = 5'b11010;
  localparam logic [4:0] OP_CALL = 5'b11100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] opcode;
  logic alu_n, alu_z, mem_ready;

  logic d1_mem_req, d1_mem_sel, d1_MemWrite, d1_ir_load, d1_ALUOp, d1_ALUSrc, d1_ExtSel;
  logic d1_RegWrite, d1_RegDst, d1_pc_enable, d1_n_flag, d1_z_flag, d1_illegal, d1_fault;
  logic [2:0] d1_WBSrc;
  logic [1:0] d1_PCSrc;
  logic d0_mem_req, d0_mem_sel, d0_MemWrite, d0_ir_load, d0_ALUOp, d0_ALUSrc, d0_ExtSel;
  logic d0_RegWrite, d0_RegDst, d0_pc_enable, d0_n_flag, d0_z_flag, d0_illegal, d0_fault;
  logic [2:0] d0_WBSrc;
  logic [1:0] d0_PCSrc;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.MAX_WAIT(16), .ARITH_SETS_NZ(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_n(alu_n), .alu_z(alu_z),
    .mem_ready(mem_ready), .mem_req(d1_mem_req), .mem_sel(d1_mem_sel),
    .MemWrite(d1_MemWrite), .ir_load(d1_ir_load), .ALUOp(d1_ALUOp), .ALUSrc(d1_ALUSrc),
    .ExtSel(d1_ExtSel), .RegWrite(d1_RegWrite), .RegDst(d1_RegDst), .WBSrc(d1_WBSrc),
    .PCSrc(d1_PCSrc), .pc_enable(d1_pc_enable), .n_flag(d1_n_flag), .z_flag(d1_z_flag),
    .illegal(d1_illegal), .fault(d1_fault)
  );

  cpu_ctrl_fsm #(.MAX_WAIT(16), .ARITH_SETS_NZ(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_n(alu_n), .alu_z(alu_z),
    .mem_ready(mem_ready), .mem_req(d0_mem_req), .mem_sel(d0_mem_sel),
    .MemWrite(d0_MemWrite), .ir_load(d0_ir_load), .ALUOp(d0_ALUOp), .ALUSrc(d0_ALUSrc),
    .ExtSel(d0_ExtSel), .RegWrite(d0_RegWrite), .RegDst(d0_RegDst), .WBSrc(d0_WBSrc),
    .PCSrc(d0_PCSrc), .pc_enable(d0_pc_enable), .n_flag(d0_n_flag), .z_flag(d0_z_flag),
    .illegal(d0_illegal), .fault(d0_fault)
  );

  typedef struct {
    logic [4:0] op;
    logic       n;
    logic       z;
    int         cyc;   // FETCH..WB inclusive, zero wait
    logic [2:0] alu;   // {ALUOp, ALUSrc, ExtSel} in EXEC
    logic [7:0] wb;    // {RegWrite, RegDst, WBSrc, PCSrc, illegal} in WB
    logic [1:0] pc0;   // PCSrc of the ARITH_SETS_NZ=0 instance in WB
    logic [1:0] fl1;   // {n,z} after the instruction, ARITH_SETS_NZ=1
    logic [1:0] fl0;   // {n,z} after the instruction, ARITH_SETS_NZ=0
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [18:0] RESET_VEC = {9'b0, 3'b000, 2'b10, 5'b0};

  function automatic vec_t mk(input logic [4:0] op, input logic n, input logic z,
                              input int cyc, input logic [2:0] alu, input logic [7:0] wb,
                              input logic [1:0] pc0, input logic [1:0] fl1,
                              input logic [1:0] fl0);
    vec_t v;
    v.op = op; v.n = n; v.z = z; v.cyc = cyc; v.alu = alu; v.wb = wb;
    v.pc0 = pc0; v.fl1 = fl1; v.fl0 = fl0;
    return v;
  endfunction

  function automatic logic [18:0] d1_all();
    return {d1_mem_req, d1_mem_sel, d1_MemWrite, d1_ir_load, d1_ALUOp, d1_ALUSrc,
            d1_ExtSel, d1_RegWrite, d1_RegDst, d1_WBSrc, d1_PCSrc, d1_pc_enable,
            d1_n_flag, d1_z_flag, d1_illegal, d1_fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fetch(input string name, input int exp_cyc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!d1_mem_req && c < 20);
    check({name, " mem_req"}, 32'(d1_mem_req), 32'd1);
    check({name, " cycles"}, c, exp_cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_MV;
    alu_n = 1'b0;
    alu_z = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'(d1_all()), 32'(RESET_VEC));
    reset = 1'b0;
    wait_fetch("reset release", 1);
  endtask

  // Runs one zero-wait instruction starting at the negedge of a FETCH cycle.
  task automatic run_row(input vec_t v, input string name);
    int c;
    check({name, " fetch"}, 32'({d1_mem_req, d1_mem_sel}), 32'(2'b10));
    opcode = v.op;
    alu_n = v.n;
    alu_z = v.z;
    mem_ready = 1'b1;
    c = 0;
    @(negedge clk); c++;
    check({name, " ir_load"}, 32'(d1_ir_load), 32'd1);
    @(negedge clk); c++;
    check({name, " exec alu"}, 32'({d1_ALUOp, d1_ALUSrc, d1_ExtSel}), 32'(v.alu));
    check({name, " exec strobes"}, 32'({d1_RegWrite, d1_pc_enable, d1_MemWrite}), 32'd0);
    do begin
      @(negedge clk); c++;
    end while (!d1_pc_enable && c < 40);
    check({name, " latency"}, c + 1, v.cyc);
    check({name, " wb"}, 32'({d1_RegWrite, d1_RegDst, d1_WBSrc, d1_PCSrc, d1_illegal}),
          32'(v.wb));
    check({name, " wb pcsrc nz0"}, 32'(d0_PCSrc), 32'(v.pc0));
    @(negedge clk);
    check({name, " refetch"}, 32'({d1_mem_req, d1_pc_enable}), 32'(2'b10));
    check({name, " flags"}, 32'({d1_n_flag, d1_z_flag}), 32'(v.fl1));
    check({name, " flags nz0"}, 32'({d0_n_flag, d0_z_flag}), 32'(v.fl0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int c;
    int cnt;
    logic bad;
    //           op        n     z    cyc alu     {RW,RD,WB,PC,ill}  pc0    fl1    fl0
    vq.push_back(mk(OP_ADD,  1'b0, 1'b0, 4, 3'b000, 8'b1_0_001_10_0, 2'b10, 2'b00, 2'b00));
    vq.push_back(mk(OP_CMPI, 1'b0, 1'b1, 4, 3'b110, 8'b0_0_000_10_0, 2'b10, 2'b01, 2'b01));
    vq.push_back(mk(OP_JZ,   1'b1, 1'b0, 4, 3'b001, 8'b0_0_000_00_0, 2'b00, 2'b01, 2'b01));
    vq.push_back(mk(OP_CMPI, 1'b0, 1'b0, 4, 3'b110, 8'b0_0_000_10_0, 2'b10, 2'b00, 2'b00));
    vq.push_back(mk(OP_JZ,   1'b1, 1'b1, 4, 3'b001, 8'b0_0_000_10_0, 2'b10, 2'b00, 2'b00));
    vq.push_back(mk(OP_ADDI, 1'b1, 1'b0, 4, 3'b010, 8'b1_0_001_10_0, 2'b10, 2'b10, 2'b00));
    vq.push_back(mk(OP_JN,   1'b0, 1'b1, 4, 3'b001, 8'b0_0_000_00_0, 2'b10, 2'b10, 2'b00));
    vq.push_back(mk(OP_JNR,  1'b0, 1'b0, 4, 3'b000, 8'b0_0_000_01_0, 2'b10, 2'b10, 2'b00));
    vq.push_back(mk(OP_SUB,  1'b0, 1'b1, 4, 3'b100, 8'b1_0_001_10_0, 2'b10, 2'b01, 2'b00));
    vq.push_back(mk(OP_JZR,  1'b1, 1'b0, 4, 3'b000, 8'b0_0_000_01_0, 2'b10, 2'b01, 2'b00));
    vq.push_back(mk(OP_CMP,  1'b1, 1'b0, 4, 3'b100, 8'b0_0_000_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_JNR,  1'b0, 1'b1, 4, 3'b000, 8'b0_0_000_01_0, 2'b01, 2'b10, 2'b10));
    vq.push_back(mk(OP_JR,   1'b0, 1'b1, 4, 3'b000, 8'b0_0_000_01_0, 2'b01, 2'b10, 2'b10));
    vq.push_back(mk(OP_J,    1'b0, 1'b1, 4, 3'b001, 8'b0_0_000_00_0, 2'b00, 2'b10, 2'b10));
    vq.push_back(mk(OP_CALL, 1'b0, 1'b1, 4, 3'b001, 8'b1_1_010_00_0, 2'b00, 2'b10, 2'b10));
    vq.push_back(mk(OP_CALLR,1'b0, 1'b1, 4, 3'b000, 8'b1_1_010_01_0, 2'b01, 2'b10, 2'b10));
    vq.push_back(mk(OP_MV,   1'b0, 1'b1, 4, 3'b000, 8'b1_0_011_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_MVI,  1'b0, 1'b1, 4, 3'b000, 8'b1_0_100_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_MVHI, 1'b0, 1'b1, 4, 3'b000, 8'b1_0_101_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_LD,   1'b0, 1'b1, 5, 3'b000, 8'b1_0_000_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_ST,   1'b0, 1'b1, 5, 3'b000, 8'b0_0_000_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(5'b11111,1'b0, 1'b1, 4, 3'b000, 8'b0_0_000_10_1, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(5'b00110,1'b0, 1'b1, 4, 3'b000, 8'b0_0_000_10_1, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_JZR,  1'b0, 1'b1, 4, 3'b000, 8'b0_0_000_10_0, 2'b10, 2'b10, 2'b10));
    vq.push_back(mk(OP_JN,   1'b0, 1'b1, 4, 3'b001, 8'b0_0_000_00_0, 2'b00, 2'b10, 2'b10));
    vq.push_back(mk(OP_ADD,  1'b1, 1'b1, 4, 3'b000, 8'b1_0_001_10_0, 2'b10, 2'b11, 2'b10));
    vq.push_back(mk(OP_SUBI, 1'b0, 1'b0, 4, 3'b110, 8'b1_0_001_10_0, 2'b10, 2'b00, 2'b10));

    do_reset();
    for (int i = 0; i < vq.size(); i++) run_row(vq[i], $sformatf("row%0d", i));

    // st with three mem_ready-low cycles in MEM.
    opcode = OP_ST;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    c = 2;
    cnt = 0;
    do begin
      @(negedge clk); c++;
      if (d1_MemWrite && d1_mem_sel && d1_mem_req) cnt++;
      mem_ready = (cnt >= 4);
    end while (!d1_pc_enable && c < 40);
    check("st wait memwrite cycles", cnt, 4);
    check("st wait latency", c + 1, 8);
    check("st wait wb regwrite", 32'(d1_RegWrite), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("st wait refetch", 32'({d1_mem_req, d1_MemWrite}), 32'(2'b10));

    // ld completing on the last allowed wait cycle: no fault.
    opcode = OP_LD;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    c = 2;
    cnt = 0;
    do begin
      @(negedge clk); c++;
      if (d1_mem_req && d1_mem_sel) cnt++;
      mem_ready = (cnt >= 16);
    end while (!d1_pc_enable && c < 60);
    check("ld boundary latency", c + 1, 20);
    check("ld boundary fault", 32'({d1_fault, d0_fault}), 32'd0);
    check("ld boundary regwrite", 32'(d1_RegWrite), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);

    // ld with mem_ready never asserted: timeout to HALT.
    opcode = OP_LD;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    c = 2;
    cnt = 0;
    do begin
      @(negedge clk); c++;
      if (d1_mem_req && d1_mem_sel && !d1_fault) cnt++;
    end while (!d1_fault && c < 60);
    check("ld timeout mem cycles", cnt, 16);
    check("ld timeout fault", 32'({d1_fault, d0_fault}), 32'(2'b11));
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("halt strobes %0d", k),
            32'({d1_mem_req, d1_MemWrite, d1_ir_load, d1_RegWrite, d1_pc_enable,
                 d1_illegal, d1_fault}), 32'(7'b0000001));
      @(negedge clk);
    end

    do_reset();

    // Reset asserted during EXEC of add aborts without WB strobes.
    opcode = OP_ADD;
    alu_n = 1'b0;
    alu_z = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset outputs", 32'(d1_all()), 32'(RESET_VEC));
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d1_RegWrite || d1_pc_enable || d1_MemWrite) bad = 1'b1;
    end
    check("mid reset no strobes", 32'(bad), 32'd0);
    reset = 1'b0;
    wait_fetch("mid reset restart", 1);
    run_row(vq[0], "post reset add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
